// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tow_pkg;

  typedef enum logic {PLAY, SERVE} field_state_t;

  localparam int unsigned NUM_LIGHTS_DEFAULT = 9;

  // Middle light of an odd-length row.
  function automatic int unsigned center_of(int unsigned num_lights);
    return (num_lights - 1) / 2;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer for a raw asynchronous key, plus a one-cycle rising-edge pulse.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level_sync,
  output logic press
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_sync = s2_q;
  assign press      = s2_q & ~s3_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: conditions both keys, walks one lit position along the LED row and
// pulses win_l / win_r for a single cycle when a player pulls the light off their end.
module tug_of_war_field
  import tow_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = NUM_LIGHTS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  key_l,
  input  logic                  key_r,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  win_l,
  output logic                  win_r
);

  localparam int unsigned POS_W = $clog2(NUM_LIGHTS);

  localparam logic [POS_W-1:0] LastPos   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0] CenterPos = POS_W'(center_of(NUM_LIGHTS));

  if ((NUM_LIGHTS < 3) || ((NUM_LIGHTS % 2) == 0)) begin : g_bad_num_lights
    $error("tug_of_war_field: NUM_LIGHTS must be odd and >= 3");
  end

  logic level_l, level_r;
  logic press_l, press_r;

  key_edge u_key_l (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_l),
    .level_sync (level_l),
    .press      (press_l)
  );

  key_edge u_key_r (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_r),
    .level_sync (level_r),
    .press      (press_r)
  );

  // Simultaneous presses cancel each other out.
  logic pull_l, pull_r;
  assign pull_l = press_l & ~press_r;
  assign pull_r = press_r & ~press_l;

  field_state_t     state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             win_l_q, win_l_d;
  logic             win_r_q, win_r_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PLAY;
      pos_q   <= CenterPos;
      win_l_q <= 1'b0;
      win_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      win_l_q <= win_l_d;
      win_r_q <= win_r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    win_l_d = 1'b0;
    win_r_d = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (enable) begin
          if (pull_l) begin
            if (pos_q == LastPos) begin
              win_l_d = 1'b1;
              state_d = SERVE;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else if (pull_r) begin
            if (pos_q == '0) begin
              win_r_d = 1'b1;
              state_d = SERVE;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
      end
      SERVE: begin
        // Wait until both keys are released so a held key cannot score in the next round.
        if (!level_l && !level_r) begin
          state_d = PLAY;
          pos_d   = CenterPos;
        end
      end
    endcase
  end

  always_comb begin
    leds = '0;
    if (state_q == PLAY) begin
      leds[pos_q] = 1'b1;
    end
  end

  assign win_l = win_l_q;
  assign win_r = win_r_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed plus randomized bench for tug_of_war_field against a queue-based reference model.
module tb_tug_of_war_field;

  localparam int N = 9;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         key_l;
  logic         key_r;
  logic [N-1:0] leds;
  logic         win_l;
  logic         win_r;

  int checks = 0;
  int errors = 0;

  // Reference model: position as an integer, key history as sampled per clock edge.
  int m_pos;
  bit m_serve;
  bit m_wl, m_wr;
  bit ql[$];
  bit qr[$];

  tug_of_war_field #(
    .NUM_LIGHTS (N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .key_l  (key_l),
    .key_r  (key_r),
    .leds   (leds),
    .win_l  (win_l),
    .win_r  (win_r)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_leds();
    logic [N-1:0] v;
    v = '0;
    if (!m_serve) v[m_pos] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_pos   = C;
    m_serve = 1'b0;
    m_wl    = 1'b0;
    m_wr    = 1'b0;
    ql      = '{1'b0, 1'b0, 1'b0};
    qr      = '{1'b0, 1'b0, 1'b0};
  endtask

  // A key seen at edge n-2 is the synchronized level acting at edge n; a press is that
  // level being high while the sample one edge earlier was low.
  task automatic model_edge();
    bit ll, lr, pl, pr;
    ll = ql[ql.size() - 2];
    lr = qr[qr.size() - 2];
    pl = ll & ~ql[ql.size() - 3];
    pr = lr & ~qr[qr.size() - 3];
    ql.push_back(key_l);
    qr.push_back(key_r);
    if (ql.size() > 4) void'(ql.pop_front());
    if (qr.size() > 4) void'(qr.pop_front());
    m_wl = 1'b0;
    m_wr = 1'b0;
    if (!m_serve) begin
      if (enable && pl && !pr) begin
        if (m_pos == N - 1) begin
          m_wl    = 1'b1;
          m_serve = 1'b1;
        end else begin
          m_pos = m_pos + 1;
        end
      end else if (enable && pr && !pl) begin
        if (m_pos == 0) begin
          m_wr    = 1'b1;
          m_serve = 1'b1;
        end else begin
          m_pos = m_pos - 1;
        end
      end
    end else if (!ll && !lr) begin
      m_serve = 1'b0;
      m_pos   = C;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_vec("leds", leds, model_leds());
    check_bit("win_l", win_l, m_wl);
    check_bit("win_r", win_r, m_wr);
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_l(input int hi, input int lo);
    key_l = 1'b1;
    cycles(hi);
    key_l = 1'b0;
    cycles(lo);
  endtask

  task automatic pulse_r(input int hi, input int lo);
    key_r = 1'b1;
    cycles(hi);
    key_r = 1'b0;
    cycles(lo);
  endtask

  // Called just after an edge; pulses reset between edges.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check_vec("rst_leds", leds, 9'h010);
    check_bit("rst_win_l", win_l, 1'b0);
    check_bit("rst_win_r", win_r, 1'b0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    key_l  = 1'b0;
    key_r  = 1'b0;
    model_reset();
    #2;
    check_vec("reset_leds", leds, 9'h010);
    check_bit("reset_win_l", win_l, 1'b0);
    check_bit("reset_win_r", win_r, 1'b0);
    #6;
    reset = 1'b0;

    cycles(3);
    check_vec("idle_center", leds, 9'h010);

    repeat (3) pulse_l(2, 4);
    check_vec("three_left", leds, 9'h080);
    key_l = 1'b1;
    cycles(20);
    key_l = 1'b0;
    cycles(4);
    check_vec("held_one_step", leds, 9'h100);

    key_l = 1'b1;
    cycles(11);
    check_vec("serve_held_dark", leds, 9'h000);
    key_l = 1'b0;
    cycles(4);
    check_vec("serve_exit_center", leds, 9'h010);

    key_l = 1'b1;
    key_r = 1'b1;
    cycles(3);
    key_l = 1'b0;
    key_r = 1'b0;
    cycles(3);
    check_vec("both_cancel", leds, 9'h010);

    repeat (4) pulse_r(2, 4);
    check_vec("right_edge", leds, 9'h001);
    pulse_r(2, 4);
    check_vec("after_win_r", leds, 9'h010);

    enable = 1'b0;
    repeat (3) pulse_r(2, 3);
    check_vec("disabled_hold", leds, 9'h010);
    enable = 1'b1;
    pulse_r(2, 4);
    check_vec("reenabled_pos3", leds, 9'h008);

    key_l = 1'b1;
    cycles(2);
    key_l = 1'b0;
    mid_reset();
    cycles(4);
    check_vec("press_lost", leds, 9'h010);

    repeat (4) pulse_l(2, 3);
    key_l = 1'b1;
    cycles(5);
    check_vec("in_serve", leds, 9'h000);
    key_l = 1'b0;
    mid_reset();
    cycles(3);
    check_vec("serve_reset_play", leds, 9'h010);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) key_l = ~key_l;
      if ($urandom_range(0, 3) == 0) key_r = ~key_r;
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) mid_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_of_war_field.md
Name: tug_of_war_field

Overview:
- Playfield controller for the tug-of-war game: conditions two raw player keys, moves a single lit position along an LED row, and detects round wins.
- Sits directly upstream of the per-player score counters: win_l / win_r are one-cycle pulses wired straight to each counter's count input.
- Handles round restart (serve) so a held key cannot leak into the next round.

Parameters:
- NUM_LIGHTS, 9, number of playfield LEDs; must be odd and >= 3 (elaboration-time check, $error otherwise).
- POS_W, $clog2(NUM_LIGHTS), width of the position register (derived, not overridden).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- enable  input  1  1 = presses accepted; 0 = presses ignored in PLAY.
- key_l  input  1  raw left-player key, active-high, asynchronous to clk.
- key_r  input  1  raw right-player key, active-high, asynchronous to clk.
- leds  output  NUM_LIGHTS  playfield lights; leds[NUM_LIGHTS-1] is leftmost, leds[0] is rightmost.
- win_l  output  1  registered one-cycle pulse; left player won the round.
- win_r  output  1  registered one-cycle pulse; right player won the round.

Behaviour:
- Key conditioning (per key): 2-flop synchronizer (s1, s2), then s3 <= s2; press = s2 & ~s3. One press per rising edge of the key, however long it is held.
- Latency: key high before edge k -> press high during cycle after edge k+1 -> position / win updated at edge k+2.
- CENTER = (NUM_LIGHTS-1)/2 (4 at default).
- States: PLAY, SERVE (package enum).
- Reset (async): state = PLAY, pos = CENTER, leds = one-hot at CENTER, win_l = win_r = 0, all sync flops 0.
- PLAY, enable = 1:
  - press_l & ~press_r: if pos < NUM_LIGHTS-1, pos <= pos+1. If pos == NUM_LIGHTS-1, win_l <= 1 and state <= SERVE.
  - press_r & ~press_l: if pos > 0, pos <= pos-1. If pos == 0, win_r <= 1 and state <= SERVE.
  - Both presses in the same cycle: cancel; no move, no win.
  - No press: hold.
- PLAY, enable = 0: all presses ignored; pos holds; no win pulses.
- SERVE:
  - leds = all zeros; presses ignored.
  - When s2_l == 0 and s2_r == 0 (both synced levels low), at the next edge: state <= PLAY, pos <= CENTER.
  - SERVE exit does not depend on enable.
- win_l / win_r: high for exactly one cycle (the edge entering SERVE); never both high; 0 in every other cycle.
- leds: in PLAY, exactly one-hot at pos; in SERVE, all zeros. Decoded combinationally from registered state and pos.
- Reset asserted mid-round or mid-SERVE: immediate return to reset values; a pending press is lost.
- pos never leaves the range 0..NUM_LIGHTS-1; there is no wrap-around.

Decomposition:
- Package tow_pkg holds:
  - typedef enum logic {PLAY, SERVE} field_state_t.
  - Localparam default NUM_LIGHTS = 9.
- Sub-module key_edge (clk, reset, key_raw -> level_sync, press): synchronizer plus rising-edge detector, instantiated once per key.

Test Plan:
- Reset, then no keys -> leds = 9'b000010000, win_l = win_r = 0.
- key_l pulsed high 2 cycles, released, 4 times -> leds moves 0x010 -> 0x020 -> 0x040 -> 0x080 -> 0x100, each change at edge k+2; key_l held 20 cycles produces exactly one step.
- From pos 8, one more key_l pulse -> win_l high exactly 1 cycle, leds = 0; key_l kept held -> stays SERVE; release -> 3 edges later leds = 0x010 in PLAY.
- key_l and key_r rising on the same edge -> no movement, no win; from pos 0 key_r -> win_r pulse, win_l stays 0.
- enable = 0 with repeated key_r pulses -> leds unchanged, no win; re-enable, then key_r -> moves to pos 3.
- Assert reset asynchronously (mid-cycle) during SERVE and during a move -> leds = 0x010, state PLAY, no win pulse emitted.
